vga_fb_arbiter: RTL and testbench

- Shares one single-port 3-bit pixel RAM (640x480 framebuffer) between two requesters: the VGA timing block's display fetch and a drawing-engine writer.
- Display fetch has priority. Writes go through in non-fetch cycles, mainly blanking.
- A starvation timer forces a pending write through if fetch traffic blocks it too long.
- Sits between the VGA timing generator (drives fetch and vsync_n, consumes pix_data) and the framebuffer RAM.

---
 rtl/vga_fb_arbiter.sv | 169 ++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : vga_fb_arbiter                                                    |
// | Brief   : Shares a single-port 3-bit pixel RAM between VGA display fetch     |
// |           (priority) and a drawing-engine writer, with a starvation override.|
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module vga_fb_arbiter #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 19,
    parameter int STARVE_MAX = 800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch,
    input  logic              vsync_n,
    output logic [2:0]        pix_data,
    output logic              pix_valid,
    input  logic              wr_req,
    input  logic [9:0]        wr_x,
    input  logic [8:0]        wr_y,
    input  logic [2:0]        wr_data,
    output logic              wr_ack,
    output logic              wr_drop,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [2:0]        mem_wdata,
    input  logic [2:0]        mem_rdata,
    output logic              underrun
);

    localparam int                 c_cnt_w      = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0]  c_frame_last = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0]  c_line_len   = ADDR_W'(H_ACTIVE);
    localparam logic [9:0]         c_h_lim      = 10'(H_ACTIVE);
    localparam logic [8:0]         c_v_lim      = 9'(V_ACTIVE);
    localparam logic [c_cnt_w-1:0] c_starve     = c_cnt_w'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]  wait_cnt_q, wait_cnt_d;
    logic [9:0]          wr_x_q, wr_x_d;
    logic [8:0]          wr_y_q, wr_y_d;
    logic [2:0]          wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                drop_q, drop_d;
    logic                rd_issue_q, rd_issue_d;
    logic                lost_q, lost_d;
    logic                pix_valid_q, pix_valid_d;
    logic [2:0]          pix_data_q, pix_data_d;
    logic                underrun_q, underrun_d;
    logic                w_fetch_ok;

    assign w_fetch_ok = fetch & vsync_n;

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wait_cnt_d  = wait_cnt_q;
        wr_x_d      = wr_x_q;
        wr_y_d      = wr_y_q;
        wr_data_d   = wr_data_q;
        wr_addr_d   = wr_addr_q;
        drop_d      = 1'b0;
        rd_issue_d  = 1'b0;
        lost_d      = 1'b0;
        mem_addr    = rd_ptr_q;
        mem_we      = 1'b0;
        mem_wdata   = 3'b000;

        // The pointer advances on every honoured fetch, even one lost to a forced write.
        if (!vsync_n) begin
            rd_ptr_d = '0;
        end else if (fetch) begin
            rd_ptr_d = (rd_ptr_q == c_frame_last) ? '0 : rd_ptr_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_req && !drop_q) begin
                    wr_x_d    = wr_x;
                    wr_y_d    = wr_y;
                    wr_data_d = wr_data;
                    if (wr_x >= c_h_lim || wr_y >= c_v_lim) begin
                        drop_d = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                wr_addr_d  = ADDR_W'(wr_y_q) * c_line_len + ADDR_W'(wr_x_q);
                wait_cnt_d = '0;
                state_d    = ST_PEND;
            end
            ST_PEND: begin
                if (!w_fetch_ok) begin
                    mem_we  = 1'b1;
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == c_starve) begin
                    mem_we  = 1'b1;
                    lost_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (mem_we) begin
            mem_addr  = wr_addr_q;
            mem_wdata = wr_data_q;
        end else if (w_fetch_ok) begin
            rd_issue_d = 1'b1;
        end

        pix_valid_d = rd_issue_q | lost_q;
        pix_data_d  = rd_issue_q ? mem_rdata : 3'b000;
        underrun_d  = lost_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_ptr_q    <= '0;
            wait_cnt_q  <= '0;
            wr_x_q      <= '0;
            wr_y_q      <= '0;
            wr_data_q   <= '0;
            wr_addr_q   <= '0;
            drop_q      <= 1'b0;
            rd_issue_q  <= 1'b0;
            lost_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wait_cnt_q  <= wait_cnt_d;
            wr_x_q      <= wr_x_d;
            wr_y_q      <= wr_y_d;
            wr_data_q   <= wr_data_d;
            wr_addr_q   <= wr_addr_d;
            drop_q      <= drop_d;
            rd_issue_q  <= rd_issue_d;
            lost_q      <= lost_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            underrun_q  <= underrun_d;
        end
    end

    assign wr_ack    = drop_q | (state_q == ST_CALC);
    assign wr_drop   = drop_q;
    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
    assign underrun  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_vga_fb_arbiter                                                 |
// | Brief   : Directed self-checking bench with a pixel scoreboard and RAM model.|
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_vga_fb_arbiter;

    localparam int H     = 640;
    localparam int V     = 4;
    localparam int FRAME = H * V;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch, vsync_n, wr_req;
    logic [9:0]  wr_x;
    logic [8:0]  wr_y;
    logic [2:0]  wr_data, pix_data, mem_wdata, mem_rdata;
    logic        pix_valid, wr_ack, wr_drop, mem_we, underrun;
    logic [18:0] mem_addr;

    typedef struct packed {
        logic       v;
        logic [2:0] d;
        logic       u;
    } pix_t;

    pix_t       sb[$];
    logic [2:0] ram    [0:4095];
    logic [2:0] shadow [0:4095];
    int         m_ptr;
    int         checks   = 0;
    int         failures = 0;

    vga_fb_arbiter #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(19), .STARVE_MAX(800)
    ) dut (
        .clk(clk), .rst(rst), .fetch(fetch), .vsync_n(vsync_n),
        .pix_data(pix_data), .pix_valid(pix_valid),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_drop(wr_drop),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .underrun(underrun)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 3'(i + 1);
    end

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[11:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[11:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero();
        chk("rst_mem_addr",  32'(mem_addr),  0);
        chk("rst_mem_we",    32'(mem_we),    0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_wr_ack",    32'(wr_ack),    0);
        chk("rst_wr_drop",   32'(wr_drop),   0);
        chk("rst_pix_valid", 32'(pix_valid), 0);
        chk("rst_pix_data",  32'(pix_data),  0);
        chk("rst_underrun",  32'(underrun),  0);
    endtask

    task automatic sb_reset();
        sb.delete();
        sb.push_back('0);
        sb.push_back('0);
        m_ptr = 0;
    endtask

    // One clock cycle: inputs are already driven; checks at the falling edge.
    task automatic tick(input bit e_we, input int e_addr, input int e_wd,
                        input bit e_ack, input bit e_drop, input bit e_force);
        pix_t e;
        pix_t n;
        @(negedge clk);
        chk("wr_ack",  32'(wr_ack),  32'(e_ack));
        chk("wr_drop", 32'(wr_drop), 32'(e_drop));
        chk("mem_we",  32'(mem_we),  32'(e_we));
        if (e_we) begin
            chk("mem_addr_wr", 32'(mem_addr), e_addr);
            chk("mem_wdata",   32'(mem_wdata), e_wd);
            shadow[e_addr] = 3'(e_wd);
        end else if (vsync_n && fetch) begin
            chk("mem_addr_rd", 32'(mem_addr), m_ptr);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chk("pix_valid", 32'(pix_valid), 32'(e.v));
        chk("underrun",  32'(underrun),  32'(e.u));
        if (e.v) chk("pix_data", 32'(pix_data), 32'(e.d));
        n = '0;
        if (!vsync_n) begin
            m_ptr = 0;
        end else if (fetch) begin
            n.v = 1'b1;
            n.d = e_force ? 3'b000 : shadow[m_ptr];
            n.u = e_force;
            m_ptr = (m_ptr == FRAME - 1) ? 0 : m_ptr + 1;
        end
        sb.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        tick(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ack_cycle(input bit drop);
        tick(1'b0, 0, 0, 1'b1, drop, 1'b0);
    endtask

    initial begin
        rst = 1'b1; fetch = 1'b0; vsync_n = 1'b1; wr_req = 1'b0;
        wr_x = '0; wr_y = '0; wr_data = '0;
        for (int i = 0; i < 4096; i++) shadow[i] = 3'(i + 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero();
        @(posedge clk); #1;
        rst = 1'b0;
        sb_reset();

        // Sync hold, then four sequential fetches of preloaded 1,2,3,4.
        vsync_n = 1'b0; step(); step();
        vsync_n = 1'b1; fetch = 1'b1;
        repeat (4) step();
        fetch = 1'b0;
        repeat (3) step();

        // In-range write (5,2) -> 1285.
        wr_x = 10'd5; wr_y = 9'd2; wr_data = 3'd6; wr_req = 1'b1;
        step();
        ack_cycle(1'b0);
        wr_req = 1'b0;
        tick(1'b1, 1285, 6, 1'b0, 1'b0, 1'b0);
        step();

        // Column and row out of range: dropped.
        wr_x = 10'd640; wr_y = 9'd0; wr_req = 1'b1;
        step();
        ack_cycle(1'b1);
        wr_req = 1'b0;
        step(); step();
        wr_x = 10'd0; wr_y = 9'd4; wr_req = 1'b1;
        step();
        ack_cycle(1'b1);
        wr_req = 1'b0;
        step();

        // FSM is idle again: write (3,0)=7 and read it back.
        wr_x = 10'd3; wr_y = 9'd0; wr_data = 3'd7; wr_req = 1'b1;
        step();
        ack_cycle(1'b0);
        wr_req = 1'b0;
        tick(1'b1, 3, 7, 1'b0, 1'b0, 1'b0);
        vsync_n = 1'b0; step();
        vsync_n = 1'b1; fetch = 1'b1;
        repeat (4) step();
        fetch = 1'b0;
        step(); step();

        // Starvation: write held off by fetch for 800 PEND cycles, then forced.
        vsync_n = 1'b0; step();
        vsync_n = 1'b1; fetch = 1'b1;
        wr_x = 10'd1; wr_y = 9'd1; wr_data = 3'd2; wr_req = 1'b1;
        step();
        ack_cycle(1'b0);
        wr_req = 1'b0;
        repeat (800) step();
        tick(1'b1, 641, 2, 1'b0, 1'b0, 1'b1);
        step();
        fetch = 1'b0;
        repeat (3) step();

        // Full frame of fetches across the wrap point, then sync vs fetch.
        vsync_n = 1'b0; step();
        vsync_n = 1'b1; fetch = 1'b1;
        repeat (FRAME + 2) step();
        vsync_n = 1'b0; step();
        vsync_n = 1'b1; step();
        fetch = 1'b0;
        repeat (3) step();

        // Reset while a write is pending.
        fetch = 1'b1;
        wr_x = 10'd2; wr_y = 9'd0; wr_data = 3'd1; wr_req = 1'b1;
        step();
        ack_cycle(1'b0);
        wr_req = 1'b0;
        step(); step();
        #2;
        rst = 1'b1;
        fetch = 1'b0;
        #1;
        chk_all_zero();
        @(posedge clk); #1;
        rst = 1'b0;
        sb_reset();
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
